// File: rtl/tcp_state_issue.sv
// Receive-pipe issue stage: issues a TCP state read per header, holds metadata in order until the
// read returns, then presents {flowid, meta, state} to the FSM. Optional TCP_ISSUE_FLOW_HAZARD_EN.
module tcp_state_issue #(
  parameter int FLOWID_W    = 8,
  parameter int TCP_STATE_W = 32,
  parameter int META_W      = 64,
  parameter int PEND_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   parser_issue_val,
  input  logic [FLOWID_W-1:0]    parser_issue_flowid,
  input  logic [META_W-1:0]      parser_issue_meta,
  output logic                   issue_parser_rdy,
  output logic                   issue_tcp_state_rd_req_val,
  output logic [FLOWID_W-1:0]    issue_tcp_state_rd_req_addr,
  input  logic                   tcp_state_issue_rd_req_rdy,
  input  logic                   tcp_state_issue_rd_resp_val,
  input  logic [TCP_STATE_W-1:0] tcp_state_issue_rd_resp_state,
  output logic                   issue_tcp_state_rd_resp_rdy,
  output logic                   issue_fsm_val,
  output logic [FLOWID_W-1:0]    issue_fsm_flowid,
  output logic [META_W-1:0]      issue_fsm_meta,
  output logic [TCP_STATE_W-1:0] issue_fsm_state,
  input  logic                   fsm_issue_rdy,
  output logic                   issue_err_unexp_resp
);

  localparam int PTR_W = $clog2(PEND_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (PEND_DEPTH < 2 || (PEND_DEPTH & (PEND_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("PEND_DEPTH must be a power of 2 and at least 2");
  end

  logic [FLOWID_W-1:0]    fifo_flowid [PEND_DEPTH];
  logic [META_W-1:0]      fifo_meta   [PEND_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   out_val;
  logic [FLOWID_W-1:0]    out_flowid;
  logic [META_W-1:0]      out_meta;
  logic [TCP_STATE_W-1:0] out_state;
  logic                   err_unexp;

  logic space;
  logic hazard;
  logic go;
  logic push;
  logic resp_rdy;
  logic resp_hs;
  logic pop;
  logic unexp;

  assign space = (count < CNT_W'(PEND_DEPTH));

`ifdef TCP_ISSUE_FLOW_HAZARD_EN
  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PTR_W-1:0] offs;
    hazard = out_val && (out_flowid == parser_issue_flowid);
    offs   = '0;
    for (int i = 0; i < PEND_DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(offs) < count) && (fifo_flowid[i] == parser_issue_flowid))
        hazard = 1'b1;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  // Combinational outputs are gated by reset so every output reads 0 while rst is low.
  assign go       = rst & parser_issue_val & space & ~hazard;
  assign push     = go & tcp_state_issue_rd_req_rdy;
  assign resp_rdy = rst & (~out_val | fsm_issue_rdy);
  assign resp_hs  = tcp_state_issue_rd_resp_val & resp_rdy;
  assign pop      = resp_hs & (count != '0);
  assign unexp    = resp_hs & (count == '0);

  assign issue_tcp_state_rd_req_val  = go;
  assign issue_tcp_state_rd_req_addr = rst ? parser_issue_flowid : '0;
  assign issue_parser_rdy            = rst & space & ~hazard & tcp_state_issue_rd_req_rdy;
  assign issue_tcp_state_rd_resp_rdy = resp_rdy;

  assign issue_fsm_val        = out_val;
  assign issue_fsm_flowid     = out_flowid;
  assign issue_fsm_meta       = out_meta;
  assign issue_fsm_state      = out_state;
  assign issue_err_unexp_resp = err_unexp;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_flowid[wr_ptr] <= parser_issue_flowid;
      fifo_meta[wr_ptr]   <= parser_issue_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (unexp) err_unexp <= 1'b1;
    end
  end

  // Output register: loads on a matched response, clears on FSM handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_val    <= 1'b0;
      out_flowid <= '0;
      out_meta   <= '0;
      out_state  <= '0;
    end else if (pop) begin
      out_val    <= 1'b1;
      out_flowid <= fifo_flowid[rd_ptr];
      out_meta   <= fifo_meta[rd_ptr];
      out_state  <= tcp_state_issue_rd_resp_state;
    end else if (fsm_issue_rdy) begin
      out_val    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tcp_state_issue.sv
// Scoreboard bench for tcp_state_issue: queue-based reference model of pending headers and the
// output slot, a behavioural state store, and a negedge monitor that checks every cycle.
module tb_tcp_state_issue;
  localparam int FW = 8;
  localparam int SW = 32;
  localparam int MW = 64;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          parser_issue_val = 1'b0;
  logic [FW-1:0] parser_issue_flowid = '0;
  logic [MW-1:0] parser_issue_meta = '0;
  logic          issue_parser_rdy;
  logic          issue_tcp_state_rd_req_val;
  logic [FW-1:0] issue_tcp_state_rd_req_addr;
  logic          tcp_state_issue_rd_req_rdy = 1'b0;
  logic          tcp_state_issue_rd_resp_val = 1'b0;
  logic [SW-1:0] tcp_state_issue_rd_resp_state = '0;
  logic          issue_tcp_state_rd_resp_rdy;
  logic          issue_fsm_val;
  logic [FW-1:0] issue_fsm_flowid;
  logic [MW-1:0] issue_fsm_meta;
  logic [SW-1:0] issue_fsm_state;
  logic          fsm_issue_rdy = 1'b0;
  logic          issue_err_unexp_resp;

  always #5 clk = ~clk;

  tcp_state_issue #(.FLOWID_W(FW), .TCP_STATE_W(SW), .META_W(MW), .PEND_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .parser_issue_val(parser_issue_val), .parser_issue_flowid(parser_issue_flowid),
    .parser_issue_meta(parser_issue_meta), .issue_parser_rdy(issue_parser_rdy),
    .issue_tcp_state_rd_req_val(issue_tcp_state_rd_req_val),
    .issue_tcp_state_rd_req_addr(issue_tcp_state_rd_req_addr),
    .tcp_state_issue_rd_req_rdy(tcp_state_issue_rd_req_rdy),
    .tcp_state_issue_rd_resp_val(tcp_state_issue_rd_resp_val),
    .tcp_state_issue_rd_resp_state(tcp_state_issue_rd_resp_state),
    .issue_tcp_state_rd_resp_rdy(issue_tcp_state_rd_resp_rdy),
    .issue_fsm_val(issue_fsm_val), .issue_fsm_flowid(issue_fsm_flowid),
    .issue_fsm_meta(issue_fsm_meta), .issue_fsm_state(issue_fsm_state),
    .fsm_issue_rdy(fsm_issue_rdy), .issue_err_unexp_resp(issue_err_unexp_resp)
  );

  typedef struct packed {
    logic [FW-1:0] f;
    logic [MW-1:0] m;
    logic [SW-1:0] s;
  } rec_t;

  // Reference model: headers accepted but not yet answered, and records waiting for the FSM.
  rec_t pend_q[$];
  rec_t exp_q[$];
  bit   m_err = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   resp_hs_cnt = 0;
  bit   drain_chk = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  bit   m_space, m_haz, e_req, e_prdy, e_rrdy, m_acc, m_rhs, m_fhs;
  rec_t r;

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_ctrl", {issue_tcp_state_rd_req_val, issue_parser_rdy, issue_tcp_state_rd_resp_rdy,
                         issue_fsm_val, issue_err_unexp_resp}, '0);
      chk("reset_fields", {issue_tcp_state_rd_req_addr, issue_fsm_flowid, issue_fsm_state}, '0);
      chk("reset_meta", issue_fsm_meta, '0);
      pend_q.delete();
      exp_q.delete();
      m_err = 1'b0;
    end else begin
      m_space = (pend_q.size() < D);
      m_haz   = 1'b0;
`ifdef TCP_ISSUE_FLOW_HAZARD_EN
      foreach (pend_q[i]) if (pend_q[i].f == parser_issue_flowid) m_haz = 1'b1;
      foreach (exp_q[i])  if (exp_q[i].f == parser_issue_flowid)  m_haz = 1'b1;
`endif
      e_req  = parser_issue_val && m_space && !m_haz;
      e_prdy = m_space && !m_haz && tcp_state_issue_rd_req_rdy;
      e_rrdy = (exp_q.size() == 0) || fsm_issue_rdy;
      chk("rd_req_val", issue_tcp_state_rd_req_val, e_req);
      if (e_req) chk("rd_req_addr", issue_tcp_state_rd_req_addr, parser_issue_flowid);
      chk("parser_rdy", issue_parser_rdy, e_prdy);
      chk("resp_rdy", issue_tcp_state_rd_resp_rdy, e_rrdy);
      chk("fsm_val", issue_fsm_val, exp_q.size() != 0);
      chk("err_unexp", issue_err_unexp_resp, m_err);
      if (exp_q.size() != 0) begin
        chk("fsm_flowid", issue_fsm_flowid, exp_q[0].f);
        chk("fsm_meta", issue_fsm_meta, exp_q[0].m);
        chk("fsm_state", issue_fsm_state, exp_q[0].s);
      end
      if (drain_chk) begin
        chk("drained_pending", pend_q.size(), 0);
        chk("drained_output", exp_q.size(), 0);
      end
      m_fhs = (exp_q.size() != 0) && fsm_issue_rdy;
      m_rhs = tcp_state_issue_rd_resp_val && e_rrdy;
      m_acc = parser_issue_val && e_prdy;
      if (m_fhs) void'(exp_q.pop_front());
      if (m_rhs) begin
        resp_hs_cnt++;
        if (pend_q.size() != 0) begin
          r   = pend_q.pop_front();
          r.s = tcp_state_issue_rd_resp_state;
          exp_q.push_back(r);
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_acc) begin
        acc_cnt++;
        r.f = parser_issue_flowid;
        r.m = parser_issue_meta;
        r.s = '0;
        pend_q.push_back(r);
      end
    end
  end

  // Stimulus side: parser, FSM readiness and an in-order state store.
  int            p_fsm = 100, p_req = 100, p_resp = 100;
  int            presented = 0, seen = 0;
  bit            fixed_en = 1'b0;
  logic [SW-1:0] fixed_state = '0;

  task automatic store_step();
    if (tcp_state_issue_rd_resp_val && resp_hs_cnt != seen) begin
      seen = resp_hs_cnt;
      tcp_state_issue_rd_resp_val = 1'b0;
    end
    if (!tcp_state_issue_rd_resp_val && acc_cnt > presented && int'($urandom_range(0, 99)) < p_resp) begin
      tcp_state_issue_rd_resp_val   = 1'b1;
      tcp_state_issue_rd_resp_state = fixed_en ? fixed_state : SW'($urandom());
      presented++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    store_step();
    fsm_issue_rdy              = int'($urandom_range(0, 99)) < p_fsm;
    tcp_state_issue_rd_req_rdy = int'($urandom_range(0, 99)) < p_req;
  endtask

  task automatic set_p(input int f, input int q, input int s);
    p_fsm = f; p_req = q; p_resp = s;
    if (f == 0)   fsm_issue_rdy = 1'b0;
    if (f == 100) fsm_issue_rdy = 1'b1;
    if (q == 0)   tcp_state_issue_rd_req_rdy = 1'b0;
    if (q == 100) tcp_state_issue_rd_req_rdy = 1'b1;
  endtask

  task automatic send(input logic [FW-1:0] f, input logic [MW-1:0] m);
    int a0, n;
    parser_issue_val    = 1'b1;
    parser_issue_flowid = f;
    parser_issue_meta   = m;
    a0 = acc_cnt;
    n  = 0;
    while (acc_cnt == a0) begin
      tick();
      n++;
      if (n > 500) begin
        $display("FAIL send_timeout: flow %0h not accepted after %0d cycles", f, n);
        $fatal(1, "header never accepted");
      end
    end
    parser_issue_val = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    set_p(100, 100, 100);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    ticks(2);

    // Single header with a known state, held while the FSM stalls.
    fixed_en = 1'b1; fixed_state = 32'h3;
    set_p(0, 100, 100);
    send(8'd5, 64'hAB);
    ticks(5);
    set_p(100, 100, 100);
    ticks(3);
    fixed_en = 1'b0;

    // Eight flows back to back.
    for (int i = 0; i < 8; i++) send(FW'(i), MW'(i + 100));
    ticks(6);

    // FSM stall fills the pending queue; a sixth header must wait.
    set_p(0, 100, 100);
    for (int i = 0; i < 5; i++) send(FW'(i + 16), {$urandom(), $urandom()});
    parser_issue_val = 1'b1; parser_issue_flowid = 8'd21; parser_issue_meta = 64'h600D;
    ticks(5);
    set_p(100, 100, 100);
    send(8'd21, 64'h600D);
    ticks(8);

    // Store refuses the request for three cycles.
    set_p(100, 0, 100);
    parser_issue_val = 1'b1; parser_issue_flowid = 8'd3; parser_issue_meta = 64'hC0DE;
    ticks(3);
    set_p(100, 100, 100);
    send(8'd3, 64'hC0DE);
    ticks(8);

    // Response with nothing pending.
    tcp_state_issue_rd_resp_val   = 1'b1;
    tcp_state_issue_rd_resp_state = 32'hDEAD;
    ticks(4);

`ifdef TCP_ISSUE_FLOW_HAZARD_EN
    set_p(0, 100, 100);
    send(8'd9, 64'h9A);
    parser_issue_val = 1'b1; parser_issue_flowid = 8'd9; parser_issue_meta = 64'h9B;
    ticks(4);
    set_p(100, 100, 100);
    send(8'd9, 64'h9B);
    ticks(6);
    set_p(0, 100, 100);
    send(8'd9, 64'h9C);
    send(8'd10, 64'hA0);
    set_p(100, 100, 100);
    ticks(6);
`endif

    // Randomized traffic with a mid-stream asynchronous reset.
    for (int it = 0; it < 400; it++) begin
      if (it % 50 == 0)
        set_p($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100));
      ticks($urandom_range(0, 2));
      send(FW'($urandom_range(0, 7)), {$urandom(), $urandom()});
      if (it == 200) begin
        parser_issue_val = 1'b1; parser_issue_flowid = 8'd4;
        #2 rst = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        parser_issue_val = 1'b0;
        tcp_state_issue_rd_resp_val = 1'b0;
        presented = acc_cnt;
        seen = resp_hs_cnt;
        rst = 1'b1;
      end
    end

    set_p(100, 100, 100);
    ticks(20);
    drain_chk = 1'b1;
    ticks(2);
    drain_chk = 1'b0;
    ticks(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_state_issue.md
Name: tcp_state_issue

Overview:
- Receive-pipe issue stage. Sits between the header parser and the TCP state FSM, directly upstream of the TCP state store's issue read port.
- Accepts parsed packet metadata tagged with a flow ID and issues a state read for that flow.
- Queues the metadata in order until the read response returns, then presents the metadata and TCP state together to the FSM stage through a one-entry output register.

Parameters:
- FLOWID_W, default tcp_pkg FLOWID_W: flow ID width.
- TCP_STATE_W, default tcp_pkg TCP_STATE_W: state record width.
- META_W, default 64: opaque packet metadata width.
- PEND_DEPTH, default 4: pending-metadata FIFO depth. Must be a power of 2 and ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- parser_issue_val  in  1  header valid
- parser_issue_flowid  in  FLOWID_W  flow of header
- parser_issue_meta  in  META_W  packet metadata
- issue_parser_rdy  out  1  header accepted
- issue_tcp_state_rd_req_val  out  1  state read request
- issue_tcp_state_rd_req_addr  out  FLOWID_W  read address
- tcp_state_issue_rd_req_rdy  in  1  store accepts request
- tcp_state_issue_rd_resp_val  in  1  read data valid
- tcp_state_issue_rd_resp_state  in  TCP_STATE_W  read data
- issue_tcp_state_rd_resp_rdy  out  1  response consumed
- issue_fsm_val  out  1  combined record valid
- issue_fsm_flowid  out  FLOWID_W  flow ID
- issue_fsm_meta  out  META_W  metadata
- issue_fsm_state  out  TCP_STATE_W  TCP state
- fsm_issue_rdy  in  1  FSM accepts record
- issue_err_unexp_resp  out  1  sticky: response arrived with FIFO empty

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - FIFO pointers and count go to 0; output register is invalidated; error flag clears.
  - All outputs read 0. A transaction in flight is dropped; upstream must also be reset.
- Space: space = (count < PEND_DEPTH). A same-cycle pop does not create room; there is no bypass.
- Issue, combinational:
  - go = parser_issue_val & space & ~hazard.
  - issue_tcp_state_rd_req_val = go; rd_req_addr = parser_issue_flowid.
  - issue_parser_rdy = space & ~hazard & tcp_state_issue_rd_req_rdy.
  - Accept = go & rd_req_rdy. On accept, {flowid, meta} is pushed at the wr pointer.
  - Without the optional feature, hazard = 0.
- Response:
  - issue_tcp_state_rd_resp_rdy = ~out_val | fsm_issue_rdy.
  - On a response handshake with count>0: pop the FIFO head and load the output register with head flowid/meta plus resp_state; out_val=1 next cycle.
- Output: issue_fsm_* are driven directly from the register. On fsm handshake with no new load, out_val clears.
- Count: push only → +1; pop only → −1; both → unchanged. Pointers are log2(PEND_DEPTH) bits and wrap naturally.
- Unexpected response (resp_val & count==0 & resp_rdy): the response is consumed and discarded; issue_err_unexp_resp sets and holds until reset.
- Ordering: responses are matched strictly in request order; the store returns reads in order.
- Latency: header accepted in cycle N, store responds N+1 at earliest, issue_fsm_val high in N+2. Throughput is 1 record/cycle when all ready signals are high.
- Backpressure:
  - FSM stall holds the output register stable.
  - resp_rdy drops, the store holds its response, the FIFO fills, and at count==PEND_DEPTH issue_parser_rdy=0.

Optional Feature:
- Macro: TCP_ISSUE_FLOW_HAZARD_EN.
- Defined:
  - hazard = 1 when parser_issue_flowid equals the flowid of any valid FIFO entry, or of the output register while out_val=1.
  - This prevents reading a state that the FSM has not yet rewritten. The header stalls with rdy=0 until no match remains.
  - Matching is combinational across all PEND_DEPTH entries.
- Not defined: hazard tied 0; back-to-back same-flow headers issue freely.

Test Plan:
- Single header flowid=5, meta=0xAB; store returns state 0x3 one cycle later → issue_fsm_val in cycle N+2 with flowid=5, meta=0xAB, state=0x3; held until fsm_issue_rdy.
- 8 headers (flows 0..7) streamed with all ready signals high → 8 records in flow order, one per cycle after the 2-cycle fill.
- fsm_issue_rdy=0 with PEND_DEPTH=4 and 6 headers offered → 4 pushed + 1 in the output register; issue_parser_rdy=0; release FSM → all 6 delivered in order, none lost.
- resp_val asserted with count=0 → issue_err_unexp_resp=1 and stays 1; no issue_fsm_val; drive rst=0 mid-stream → all outputs 0 asynchronously, count=0.
- With TCP_ISSUE_FLOW_HAZARD_EN: headers flowid=9 then 9 → second held (rdy=0) until the first record handshakes with the FSM, then issued; flowid=9 then 10 → no stall.
- tcp_state_issue_rd_req_rdy=0 for 3 cycles → issue_parser_rdy=0, no push; rd_req_val stays high with addr stable.
